// File: rtl/uart_report_scheduler_pkg.sv
// Shared types and constants for the UART report scheduler: FSM states,
// frame type codes and the pending-bit priority order (index 0 = highest).
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic [2:0] MSG_NONE  = 3'd0;
    localparam logic [2:0] MSG_COORD = 3'd1;
    localparam logic [2:0] MSG_LIGHT = 3'd2;
    localparam logic [2:0] MSG_WARN  = 3'd3;
    localparam logic [2:0] MSG_TIME  = 3'd4;

    localparam int PRIO_WARN  = 0;
    localparam int PRIO_LIGHT = 1;
    localparam int PRIO_COORD = 2;
    localparam int PRIO_TIME  = 3;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/uart_report_scheduler_if.sv
// Frame handshake between the report scheduler (master) and the UART sender (slave).
interface uart_report_scheduler_if;
    logic        tx_start;
    logic [2:0]  msg_type;
    logic [39:0] payload;
    logic        tx_busy;
    logic        tx_done;

    modport master (output tx_start, output msg_type, output payload,
                    input  tx_busy,  input  tx_done);
    modport slave  (input  tx_start, input  msg_type, input  payload,
                    output tx_busy,  output tx_done);
endinterface

// File: rtl/uart_report_scheduler_prio_arb.sv
// Fixed-priority one-hot grant over the four pending bits; bit 0 wins.
module sched_prio_arb (
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       any_req
);

    // Lowest set index gets the grant.
    always_comb begin
        grant   = 4'b0000;
        any_req = |req;
        if (req[0]) begin
            grant = 4'b0001;
        end else if (req[1]) begin
            grant = 4'b0010;
        end else if (req[2]) begin
            grant = 4'b0100;
        end else if (req[3]) begin
            grant = 4'b1000;
        end else begin
            grant = 4'b0000;
        end
    end

endmodule

// File: rtl/uart_report_scheduler.sv
// Collects report events into sticky pending bits and feeds one frame at a
// time to the UART sender, with a done-timeout and an inter-frame gap.
module uart_report_scheduler
    import uart_sched_pkg::*;
#(
    parameter int MIN_GAP_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fix_coord_valid,
    input  logic        tr_light_valid,
    input  logic        val_warn_car,
    input  logic        val_warn_human,
    input  logic        tick_sec,
    input  logic [9:0]  x_min,
    input  logic [9:0]  x_max,
    input  logic [9:0]  y_min,
    input  logic [9:0]  y_max,
    input  logic        tr_light,
    input  logic [4:0]  red_left_time,
    input  logic [4:0]  green_left_time,
    input  logic        warn_car,
    input  logic        warn_human,
    input  logic        traffic_amount,
    uart_report_scheduler_if.master tx,
    output logic        sched_busy,
    output logic [7:0]  drop_count,
    output logic        timeout_err
);

    localparam int CNT_MAX      = (TIMEOUT_CYCLES > MIN_GAP_CYCLES) ? TIMEOUT_CYCLES : MIN_GAP_CYCLES;
    localparam int CNT_W        = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
    localparam int GAP_LAST     = (MIN_GAP_CYCLES < 1) ? 0 : MIN_GAP_CYCLES - 1;

    state_t             state_r;
    logic [3:0]         pend_r;
    logic [3:0]         req_s;
    logic [3:0]         clr_s;
    logic [3:0]         drop_s;
    logic [3:0]         grant_s;
    logic               any_pend_s;
    logic [8:0]         drop_sum_s;
    logic [7:0]         drop_count_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               tx_start_r;
    logic [2:0]         msg_type_r;
    logic [39:0]        payload_r;
    logic               timeout_err_r;

    sched_prio_arb u_arb (
        .req     (pend_r),
        .grant   (grant_s),
        .any_req (any_pend_s)
    );

    // Map event pulses onto pending-bit positions and work out clears and drops.
    always_comb begin
        req_s             = 4'b0000;
        req_s[PRIO_WARN]  = val_warn_car | val_warn_human;
        req_s[PRIO_LIGHT] = tr_light_valid;
        req_s[PRIO_COORD] = fix_coord_valid;
        req_s[PRIO_TIME]  = tick_sec;
        if (state_r == LOAD) begin
            clr_s = grant_s;
        end else begin
            clr_s = 4'b0000;
        end
        // A request racing its own clear re-arms the bit and is not a drop.
        drop_s     = req_s & pend_r & ~clr_s;
        drop_sum_s = {1'b0, drop_count_r} + {6'b000000, popcount4(drop_s)};
    end

    // Sticky pending bits and the saturating coalesce counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r       <= 4'b0000;
            drop_count_r <= 8'd0;
        end else begin
            pend_r       <= (pend_r & ~clr_s) | req_s;
            drop_count_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        end
    end

    // Frame sequencer; cnt_r times both the done-wait and the gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            tx_start_r    <= 1'b0;
            msg_type_r    <= MSG_NONE;
            payload_r     <= 40'd0;
            cnt_r         <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (any_pend_s || (|req_s)) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    state_r <= SEND;
                    if (grant_s[PRIO_WARN]) begin
                        msg_type_r <= MSG_WARN;
                        payload_r  <= {37'd0, warn_car, warn_human, traffic_amount};
                    end else if (grant_s[PRIO_LIGHT]) begin
                        msg_type_r <= MSG_LIGHT;
                        payload_r  <= {29'd0, tr_light, red_left_time, green_left_time};
                    end else if (grant_s[PRIO_COORD]) begin
                        msg_type_r <= MSG_COORD;
                        payload_r  <= {x_min, x_max, y_min, y_max};
                    end else if (grant_s[PRIO_TIME]) begin
                        msg_type_r <= MSG_TIME;
                        payload_r  <= {29'd0, tr_light, red_left_time, green_left_time};
                    end else begin
                        msg_type_r <= MSG_NONE;
                        payload_r  <= 40'd0;
                    end
                end
                SEND: begin
                    if (!tx.tx_busy) begin
                        tx_start_r <= 1'b1;
                        cnt_r      <= '0;
                        state_r    <= WAIT;
                    end else begin
                        state_r    <= SEND;
                    end
                end
                WAIT: begin
                    if (tx.tx_done) begin
                        cnt_r   <= '0;
                        state_r <= GAP;
                    end else if (cnt_r >= CNT_W'(TIMEOUT_LAST)) begin
                        timeout_err_r <= 1'b1;
                        cnt_r         <= '0;
                        state_r       <= GAP;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                GAP: begin
                    if (cnt_r >= CNT_W'(GAP_LAST)) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_start  = tx_start_r;
    assign tx.msg_type  = msg_type_r;
    assign tx.payload   = payload_r;
    assign sched_busy   = (state_r != IDLE);
    assign drop_count   = drop_count_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Directed bench for uart_report_scheduler: a payload/type vector table plus
// hand-written sequences for priority, coalescing, busy hold-off, timeout and reset.
module tb_uart_report_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        fix_coord_valid, tr_light_valid, val_warn_car, val_warn_human, tick_sec;
    logic [9:0]  x_min, x_max, y_min, y_max;
    logic        tr_light;
    logic [4:0]  red_left_time, green_left_time;
    logic        warn_car, warn_human, traffic_amount;
    logic        sched_busy;
    logic [7:0]  drop_count;
    logic        timeout_err;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    uart_report_scheduler_if tx_if ();

    uart_report_scheduler #(.MIN_GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset),
        .fix_coord_valid(fix_coord_valid), .tr_light_valid(tr_light_valid),
        .val_warn_car(val_warn_car), .val_warn_human(val_warn_human), .tick_sec(tick_sec),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .tr_light(tr_light), .red_left_time(red_left_time), .green_left_time(green_left_time),
        .warn_car(warn_car), .warn_human(warn_human), .traffic_amount(traffic_amount),
        .tx(tx_if), .sched_busy(sched_busy), .drop_count(drop_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure start-to-done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  ev;      // {tick, coord, light, warn_human, warn_car}
        logic [9:0]  xa, xb, ya, yb;
        logic        tl;
        logic [4:0]  rt, gt;
        logic        wc, wh, ta;
        logic [2:0]  exp_msg;
        logic [39:0] exp_pl;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [4:0] ev);
        val_warn_car    = ev[0];
        val_warn_human  = ev[1];
        tr_light_valid  = ev[2];
        fix_coord_valid = ev[3];
        tick_sec        = ev[4];
        step();
        {tick_sec, fix_coord_valid, tr_light_valid, val_warn_human, val_warn_car} = 5'b00000;
    endtask

    task automatic done_pulse();
        tx_if.tx_done = 1'b1;
        step();
        tx_if.tx_done = 1'b0;
    endtask

    task automatic wait_start(input string nm, input int budget);
        int n = 0;
        while (tx_if.tx_start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(nm, {39'd0, tx_if.tx_start}, 40'd1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (sched_busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk(nm, {39'd0, sched_busy}, 40'd0);
    endtask

    initial begin
        logic [2:0] order [3];
        int         done_at;
        int         start_at;
        logic       saw;

        vecs[0] = '{5'b10000, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b0, 3'd4, 40'h00_0000_04E0};
        vecs[1] = '{5'b00100, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 5'd0,  5'd19, 1'b0, 1'b0, 1'b0, 3'd2, 40'h00_0000_0013};
        vecs[2] = '{5'b01000, 10'd1, 10'd2, 10'd3, 10'd1023, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd1, 40'h00_4020_0FFF};
        vecs[3] = '{5'b00010, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 3'd3, 40'h00_0000_0005};
        vecs[4] = '{5'b00001, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 5'd9,  5'd9,  1'b0, 1'b1, 1'b0, 3'd3, 40'h00_0000_0002};
        vecs[5] = '{5'b10000, 10'd5, 10'd5, 10'd5, 10'd5, 1'b0, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 3'd4, 40'h00_0000_03FF};

        reset = 1'b1;
        {tick_sec, fix_coord_valid, tr_light_valid, val_warn_human, val_warn_car} = 5'b00000;
        {x_min, x_max, y_min, y_max} = 40'd0;
        tr_light = 1'b0; red_left_time = 5'd0; green_left_time = 5'd0;
        {warn_car, warn_human, traffic_amount} = 3'b000;
        tx_if.tx_busy = 1'b0;
        tx_if.tx_done = 1'b0;
        @(negedge clk);
        step(); step();
        chk("rst_tx_start", {39'd0, tx_if.tx_start}, 40'd0);
        chk("rst_msg_type", {37'd0, tx_if.msg_type}, 40'd0);
        chk("rst_payload", tx_if.payload, 40'd0);
        chk("rst_busy_drop_to", {30'd0, sched_busy, drop_count, timeout_err}, 40'd0);
        reset = 1'b0;
        step();

        // Table: one event per frame, type and payload, latency and hold.
        for (int i = 0; i < 6; i++) begin
            {x_min, x_max, y_min, y_max} = {vecs[i].xa, vecs[i].xb, vecs[i].ya, vecs[i].yb};
            tr_light = vecs[i].tl; red_left_time = vecs[i].rt; green_left_time = vecs[i].gt;
            {warn_car, warn_human, traffic_amount} = {vecs[i].wc, vecs[i].wh, vecs[i].ta};
            pulse(vecs[i].ev);
            chk($sformatf("v%0d_busy_n", i), {39'd0, sched_busy}, 40'd1);
            chk($sformatf("v%0d_start_n", i), {39'd0, tx_if.tx_start}, 40'd0);
            step();
            chk($sformatf("v%0d_start_n1", i), {39'd0, tx_if.tx_start}, 40'd0);
            step();
            chk($sformatf("v%0d_start_n2", i), {39'd0, tx_if.tx_start}, 40'd1);
            chk($sformatf("v%0d_msg", i), {37'd0, tx_if.msg_type}, {37'd0, vecs[i].exp_msg});
            chk($sformatf("v%0d_payload", i), tx_if.payload, vecs[i].exp_pl);
            {x_min, x_max, y_min, y_max} = ~40'd0;
            tr_light = ~vecs[i].tl; red_left_time = ~vecs[i].rt; green_left_time = ~vecs[i].gt;
            {warn_car, warn_human, traffic_amount} = ~{vecs[i].wc, vecs[i].wh, vecs[i].ta};
            step();
            chk($sformatf("v%0d_start_n3", i), {39'd0, tx_if.tx_start}, 40'd0);
            step(); step();
            chk($sformatf("v%0d_hold", i), tx_if.payload, vecs[i].exp_pl);
            done_pulse();
            wait_idle($sformatf("v%0d_idle", i), 30);
        end

        // Simultaneous WARN, COORD, TIME: priority order and gap spacing.
        order[0] = 3'd3; order[1] = 3'd1; order[2] = 3'd4;
        done_at = 0;
        pulse(5'b11001);
        for (int k = 0; k < 3; k++) begin
            wait_start($sformatf("prio%0d_start", k), 40);
            start_at = cyc;
            chk($sformatf("prio%0d_msg", k), {37'd0, tx_if.msg_type}, {37'd0, order[k]});
            if (k > 0) chk($sformatf("prio%0d_gap", k), {39'd0, (start_at - done_at) >= 5}, 40'd1);
            for (int j = 0; j < 49; j++) step();
            done_pulse();
            done_at = cyc;
        end
        wait_idle("prio_idle", 30);
        chk("prio_drop", {32'd0, drop_count}, 40'd0);

        // Three ticks during WAIT coalesce into one TIME frame.
        pulse(5'b00100);
        wait_start("coal_light_start", 10);
        for (int k = 0; k < 3; k++) begin
            pulse(5'b10000);
            step();
        end
        done_pulse();
        wait_start("coal_time_start", 20);
        chk("coal_time_msg", {37'd0, tx_if.msg_type}, 40'd4);
        step();
        done_pulse();
        wait_idle("coal_idle", 20);
        saw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            saw = saw | tx_if.tx_start;
        end
        chk("coal_no_extra", {39'd0, saw}, 40'd0);
        chk("coal_drop", {32'd0, drop_count}, 40'd2);

        // tx_busy holds the frame in SEND without a start pulse.
        tx_if.tx_busy = 1'b1;
        pulse(5'b00100);
        saw = tx_if.tx_start;
        for (int k = 0; k < 20; k++) begin
            step();
            saw = saw | tx_if.tx_start;
        end
        chk("busy_no_start", {39'd0, saw}, 40'd0);
        chk("busy_held", {39'd0, sched_busy}, 40'd1);
        tx_if.tx_busy = 1'b0;
        step();
        chk("busy_start", {39'd0, tx_if.tx_start}, 40'd1);
        step();
        chk("busy_start_1cyc", {39'd0, tx_if.tx_start}, 40'd0);
        done_pulse();
        wait_idle("busy_idle", 20);

        // Done never returns: timeout after 100 WAIT cycles, then next request.
        pulse(5'b01000);
        wait_start("to_start", 10);
        tick_sec = 1'b1;
        for (int k = 0; k < 99; k++) begin
            step();
            tick_sec = 1'b0;
        end
        chk("to_before", {39'd0, timeout_err}, 40'd0);
        step();
        chk("to_flag", {39'd0, timeout_err}, 40'd1);
        wait_start("to_next_start", 20);
        chk("to_next_msg", {37'd0, tx_if.msg_type}, 40'd4);
        step();
        done_pulse();
        wait_idle("to_idle", 20);
        chk("to_sticky", {39'd0, timeout_err}, 40'd1);

        // Reset mid-WAIT with LIGHT pending discards everything.
        pulse(5'b01000);
        wait_start("rst_mid_start", 10);
        pulse(5'b00100);
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_tx_start", {39'd0, tx_if.tx_start}, 40'd0);
        chk("rst_mid_msg", {37'd0, tx_if.msg_type}, 40'd0);
        chk("rst_mid_payload", tx_if.payload, 40'd0);
        chk("rst_mid_status", {30'd0, sched_busy, drop_count, timeout_err}, 40'd0);
        reset = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            saw = saw | tx_if.tx_start | sched_busy;
        end
        chk("rst_mid_quiet", {39'd0, saw}, 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_report_scheduler.md
Name: uart_report_scheduler

Overview:
- Arbitrates the event pulses that report to the host over UART: coordinate fix, light change, car/human warning, and 1 s tick.
- Snapshots the matching payload and sequences one frame at a time into the UART sender using a start/busy/done handshake.
- Sits between Decision_CrossWalk / Signal_CU / motion_detect and sender_uart, replacing the OR-of-valids trigger.
- Guarantees no event is lost while a frame is in flight. Repeats of the same event are coalesced and counted.

Parameters:
- MIN_GAP_CYCLES, 1000: idle clk cycles enforced between frames; 0 means no gap.
- TIMEOUT_CYCLES, 2000000: maximum clk cycles to wait for tx_done before aborting the frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fix_coord_valid  in  1  pulse: crosswalk coordinates fixed
- tr_light_valid  in  1  pulse: traffic light changed
- val_warn_car  in  1  pulse: car-violation state updated
- val_warn_human  in  1  pulse: human-violation state updated
- tick_sec  in  1  pulse: one second elapsed
- x_min, x_max, y_min, y_max  in  10 each  crosswalk coordinates
- tr_light  in  1  current light, 0=green, 1=red
- red_left_time, green_left_time  in  5 each  remaining seconds
- warn_car, warn_human, traffic_amount  in  1 each  status levels
- tx_busy  in  1  sender is transmitting
- tx_done  in  1  pulse: frame fully sent
- tx_start  out  1  one-cycle frame start
- msg_type  out  3  frame type, held for the whole frame
- payload  out  40  frame data, held for the whole frame
- sched_busy  out  1  scheduler is not IDLE
- drop_count  out  8  saturating count of coalesced requests
- timeout_err  out  1  sticky flag: a done-timeout occurred

Behaviour:
- Reset values: all outputs 0; msg_type=MSG_NONE(0); all pending bits 0; FSM in IDLE.
- Pending bits: 4 sticky bits.
  - WARN is set by val_warn_car | val_warn_human.
  - LIGHT is set by tr_light_valid.
  - COORD is set by fix_coord_valid.
  - TIME is set by tick_sec.
- A request arriving while its bit is already set leaves the bit set and increments drop_count. drop_count saturates at 255.
- A set and a clear of the same bit in the same cycle: the set wins, and the request is not counted as dropped.
- Fixed priority: WARN > LIGHT > COORD > TIME.
- Payload formats (msb first), captured from the live inputs in LOAD:
  - COORD (1): {x_min, x_max, y_min, y_max}.
  - LIGHT (2): {29'b0, tr_light, red_left_time, green_left_time}.
  - WARN (3): {37'b0, warn_car, warn_human, traffic_amount}.
  - TIME (4): {29'b0, tr_light, red_left_time, green_left_time}.
- FSM states:
  - IDLE: if any pending bit is set, go to LOAD.
  - LOAD (1 cycle): grant the highest-priority pending bit, clear it, register msg_type and payload; go to SEND.
  - SEND: when tx_busy=0, assert tx_start for exactly one cycle and go to WAIT. While tx_busy=1, hold in SEND without asserting tx_start.
  - WAIT: on tx_done, go to GAP. If the wait counter reaches TIMEOUT_CYCLES first, set timeout_err and go to GAP. A tx_done in the same cycle as the timeout counts as done, not timeout.
  - GAP: count MIN_GAP_CYCLES, then go to IDLE. With MIN_GAP_CYCLES=0, GAP lasts 1 cycle.
- Latency: a request pulse at edge N (FSM IDLE, tx_busy=0) produces LOAD at N+1 and tx_start high during cycle N+2.
- msg_type and payload stay stable from LOAD until the next LOAD. Input changes during a frame do not alter the frame in flight.
- Requests arriving during LOAD/SEND/WAIT/GAP only set pending bits. They are served after GAP, by priority.
- sched_busy = (state != IDLE).
- reset asserted mid-frame returns to the reset values on the next edge. Pending events are discarded and no tx_start is issued.

Decomposition:
- Package uart_sched_pkg holds:
  - the state_t enum {IDLE, LOAD, SEND, WAIT, GAP};
  - msg_type constants MSG_NONE/COORD/LIGHT/WARN/TIME;
  - the priority-index constants.
- One sub-module: sched_prio_arb, a combinational 4-bit fixed-priority one-hot grant plus an any_req output.

Test Plan:
- Single tick_sec, red_left_time=7, tr_light=1, idle sender → tx_start in cycle N+2; msg_type=4; payload[10:0]={1,7,0}.
- fix_coord_valid, val_warn_car, tick_sec in the same cycle, tx_done returned 50 cycles after each start, MIN_GAP_CYCLES=4 → frames sent in order WARN(3), COORD(1), TIME(4); each start separated by ≥ done+5 cycles.
- tick_sec pulsed 3 times while a frame is in WAIT → exactly one TIME frame follows; drop_count=2.
- tx_busy held high for 20 cycles after LOAD → tx_start stays 0 throughout, then a single 1-cycle pulse after tx_busy drops.
- TIMEOUT_CYCLES=100, tx_done never asserted → timeout_err=1 at cycle 100 of WAIT; FSM passes through GAP and serves the next pending request.
- reset asserted during WAIT with LIGHT pending → next edge: all outputs 0, FSM IDLE, no further tx_start without new requests.
